// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and default sizing for the SPI RAM arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_t;

   localparam int DEF_AW             = 8;
   localparam int DEF_DW             = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Requester and SPI-master signals of the arbiter; slave = arbiter view, master = environment view.
interface spi_ram_arbiter_if
   import spi_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_ack;
   logic [DW-1:0] f_rdata;
   logic          f_err;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          d_err;

   logic          m_start;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_done;
   logic [DW-1:0] m_rdata;

   logic          busy;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_done, m_rdata,
      output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
      output m_start, m_we, m_addr, m_wdata, busy
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_done, m_rdata,
      input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
      input  m_start, m_we, m_addr, m_wdata, busy
   );
endinterface

// File: rtl/spi_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port that did not own the last transaction wins.
module rr_arbiter2
   import spi_arb_pkg::*;
(
   input  logic   f_req,
   input  logic   d_req,
   input  owner_t last_owner,
   output logic   grant_valid,
   output owner_t grant_owner
);
   always_comb begin
      grant_valid = f_req | d_req;
      grant_owner = FETCH;
      if (f_req && d_req) begin
         grant_owner = (last_owner == FETCH) ? DATA : FETCH;
      end else if (d_req) begin
         grant_owner = DATA;
      end
   end
endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one SPI RAM master between instruction fetch and data port, one transaction at a time.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT-state watchdog that answers with an error flag.
module spi_ram_arbiter
   import spi_arb_pkg::*;
#(
   parameter int AW             = DEF_AW,
   parameter int DW             = DEF_DW,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic              clk,
   input logic              rst,
   spi_ram_arbiter_if.slave bus
);
   state_t        state_reg;
   owner_t        owner_reg;
   owner_t        last_owner_reg;
   owner_t        grant_owner;
   logic          grant_valid;
   logic          f_ack_reg;
   logic          d_ack_reg;
   logic          m_start_reg;
   logic          m_we_reg;
   logic          busy_reg;
   logic [AW-1:0] m_addr_reg;
   logic [DW-1:0] m_wdata_reg;
   logic [DW-1:0] f_rdata_reg;
   logic [DW-1:0] d_rdata_reg;

   rr_arbiter2 u_rr (
      .f_req       (bus.f_req),
      .d_req       (bus.d_req),
      .last_owner  (last_owner_reg),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int            CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] wd_cnt_reg;
   logic          f_err_reg;
   logic          d_err_reg;
   assign bus.f_err = f_err_reg;
   assign bus.d_err = d_err_reg;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign bus.f_err = 1'b0;
   assign bus.d_err = 1'b0;
`endif

   assign bus.f_ack   = f_ack_reg;
   assign bus.d_ack   = d_ack_reg;
   assign bus.f_rdata = f_rdata_reg;
   assign bus.d_rdata = d_rdata_reg;
   assign bus.m_start = m_start_reg;
   assign bus.m_we    = m_we_reg;
   assign bus.m_addr  = m_addr_reg;
   assign bus.m_wdata = m_wdata_reg;
   assign bus.busy    = busy_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         owner_reg      <= FETCH;
         last_owner_reg <= FETCH;
         f_ack_reg      <= 1'b0;
         d_ack_reg      <= 1'b0;
         m_start_reg    <= 1'b0;
         m_we_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         m_addr_reg     <= '0;
         m_wdata_reg    <= '0;
         f_rdata_reg    <= '0;
         d_rdata_reg    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         wd_cnt_reg     <= '0;
         f_err_reg      <= 1'b0;
         d_err_reg      <= 1'b0;
`endif
      end else begin
         // Acks, errors and m_start are single-cycle pulses.
         f_ack_reg   <= 1'b0;
         d_ack_reg   <= 1'b0;
         m_start_reg <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         f_err_reg   <= 1'b0;
         d_err_reg   <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  owner_reg   <= grant_owner;
                  busy_reg    <= 1'b1;
                  m_start_reg <= 1'b1;
                  state_reg   <= ISSUE;
                  if (grant_owner == DATA) begin
                     m_we_reg    <= bus.d_we;
                     m_addr_reg  <= bus.d_addr;
                     m_wdata_reg <= bus.d_wdata;
                  end else begin
                     m_we_reg    <= 1'b0;
                     m_addr_reg  <= bus.f_addr;
                     m_wdata_reg <= '0;
                  end
               end
            end
            ISSUE: begin
               state_reg <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
               wd_cnt_reg <= '0;
`endif
            end
            WAIT: begin
               // m_done wins over watchdog expiry in the same cycle.
               if (bus.m_done) begin
                  if (owner_reg == FETCH) begin
                     f_rdata_reg <= bus.m_rdata;
                  end else if (!m_we_reg) begin
                     d_rdata_reg <= bus.m_rdata;
                  end
                  f_ack_reg <= (owner_reg == FETCH);
                  d_ack_reg <= (owner_reg == DATA);
                  state_reg <= RESP;
               end
`ifdef SPI_ARB_TIMEOUT_EN
               else if (wd_cnt_reg == WD_LAST) begin
                  if (owner_reg == FETCH) begin
                     f_rdata_reg <= '0;
                     f_ack_reg   <= 1'b1;
                     f_err_reg   <= 1'b1;
                  end else begin
                     if (!m_we_reg) begin
                        d_rdata_reg <= '0;
                     end
                     d_ack_reg <= 1'b1;
                     d_err_reg <= 1'b1;
                  end
                  state_reg <= RESP;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 1'b1;
               end
`endif
            end
            RESP: begin
               last_owner_reg <= owner_reg;
               busy_reg       <= 1'b0;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a latency-3 RAM master model; honours SPI_ARB_TIMEOUT_EN.
module tb_spi_ram_arbiter;
   import spi_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_ram_arbiter_if #(.AW(8), .DW(8)) bus ();

   spi_ram_arbiter #(.AW(8), .DW(8), .TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit         port;      // 0 = fetch, 1 = data
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata; // owner's rdata in the ack cycle
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic [7:0] ram [256];
   bit  master_stuck = 1'b0;
   bit  pend;
   int  lat;

   int         cyc = 0;
   int         start_cnt = 0;
   int         overlap_cnt = 0;
   int         start_cyc = 0;
   logic [7:0] start_addr = '0;
   logic       start_we = 1'b0;
   bit         outstanding = 1'b0;
   int         f_ack_cnt = 0;
   int         d_ack_cnt = 0;

   always @(posedge clk) cyc++;

   // RAM master model: m_done three cycles after seeing m_start.
   initial begin
      bus.m_done  = 1'b0;
      bus.m_rdata = '0;
      pend = 1'b0;
      lat  = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.m_done = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else if (bus.m_start) begin
            pend = !master_stuck;
            lat  = 2;
         end else if (pend) begin
            if (lat == 0) begin
               bus.m_done  = 1'b1;
               bus.m_rdata = ram[bus.m_addr];
               if (bus.m_we) ram[bus.m_addr] = bus.m_wdata;
               pend = 1'b0;
            end else begin
               lat--;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         outstanding = 1'b0;
      end else begin
         if (bus.m_start) begin
            start_cnt++;
            if (outstanding) overlap_cnt++;
            outstanding = 1'b1;
            start_addr  = bus.m_addr;
            start_we    = bus.m_we;
            start_cyc   = cyc;
         end
         if (bus.f_ack) begin f_ack_cnt++; outstanding = 1'b0; end
         if (bus.d_ack) begin d_ack_cnt++; outstanding = 1'b0; end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ack(input int max_cyc, output bit got_f, output bit got_d,
                           output bit timed_out, output int idle_cyc, output bit done_before);
      bit prev_done;
      prev_done = 1'b0;
      got_f = 1'b0; got_d = 1'b0; timed_out = 1'b1; idle_cyc = 0; done_before = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (bus.f_ack || bus.d_ack) begin
            got_f = bus.f_ack;
            got_d = bus.d_ack;
            timed_out = 1'b0;
            done_before = prev_done;
            break;
         end
         if (!bus.busy) idle_cyc++;
         prev_done = bus.m_done;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"},    bus.busy,    0);
      check({tag, "_f_ack"},   bus.f_ack,   0);
      check({tag, "_d_ack"},   bus.d_ack,   0);
      check({tag, "_m_start"}, bus.m_start, 0);
      check({tag, "_m_we"},    bus.m_we,    0);
      check({tag, "_m_addr"},  bus.m_addr,  0);
      check({tag, "_m_wdata"}, bus.m_wdata, 0);
      check({tag, "_f_rdata"}, bus.f_rdata, 0);
      check({tag, "_d_rdata"}, bus.d_rdata, 0);
      check({tag, "_errs"},    {bus.f_err, bus.d_err}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int fa0, da0, s0, idle;
      bit gf, gd, to, db;
      fa0 = f_ack_cnt; da0 = d_ack_cnt; s0 = start_cnt;
      if (v.port) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.f_req = 1'b1; bus.f_addr = v.addr;
      end
      wait_ack(50, gf, gd, to, idle, db);
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      $display("txn v%0d port=%s we=%0d addr=0x%02h ack=%0d%0d rdata f=0x%02h d=0x%02h",
               idx, v.port ? "D" : "F", v.we, v.addr, gf, gd, bus.f_rdata, bus.d_rdata);
      check($sformatf("v%0d_timeout", idx), to, 0);
      check($sformatf("v%0d_ack_port", idx), {gf, gd}, v.port ? 2'b01 : 2'b10);
      check($sformatf("v%0d_other_ack", idx), v.port ? (f_ack_cnt - fa0) : (d_ack_cnt - da0), 0);
      check($sformatf("v%0d_starts", idx), start_cnt - s0, 1);
      check($sformatf("v%0d_m_addr", idx), start_addr, v.addr);
      check($sformatf("v%0d_m_we", idx), start_we, v.port ? v.we : 1'b0);
      check($sformatf("v%0d_done_before_ack", idx), db, 1);
      check($sformatf("v%0d_rdata", idx), v.port ? bus.d_rdata : bus.f_rdata, v.exp_rdata);
      check($sformatf("v%0d_err", idx), {bus.f_err, bus.d_err}, 0);
   endtask

   vec_t vecs [7];

   initial begin
      int s0, fa0, da0, idle, c_ack;
      bit gf, gd, to, db;

      vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h12, wdata: 8'h00, exp_rdata: 8'hA5};
      vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'h40, wdata: 8'h3C, exp_rdata: 8'h00};
      vecs[2] = '{port: 1'b1, we: 1'b0, addr: 8'h40, wdata: 8'h00, exp_rdata: 8'h3C};
      vecs[3] = '{port: 1'b0, we: 1'b0, addr: 8'h40, wdata: 8'h00, exp_rdata: 8'h3C};
      vecs[4] = '{port: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 8'h81, exp_rdata: 8'h3C};
      vecs[5] = '{port: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h81};
      vecs[6] = '{port: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h5A};

      for (int i = 0; i < 256; i++) ram[i] = 8'(i * 3 + 1);
      ram[8'h12] = 8'hA5;
      ram[8'h10] = 8'h99;
      ram[8'h20] = 8'h77;
      ram[8'h00] = 8'h5A;

      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      do_reset();
      check_reset_state("rst0");

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Simultaneous requests right after reset: data wins the first tie.
      do_reset();
      s0 = start_cnt;
      bus.f_req = 1'b1; bus.f_addr = 8'h10;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
      wait_ack(50, gf, gd, to, idle, db);
      bus.d_req = 1'b0;
      $display("txn sim1 ack=%0d%0d d_rdata=0x%02h", gf, gd, bus.d_rdata);
      check("sim_first_ack", {gf, gd}, 2'b01);
      check("sim_first_rdata", bus.d_rdata, 8'h77);
      wait_ack(50, gf, gd, to, idle, db);
      bus.f_req = 1'b0;
      $display("txn sim2 ack=%0d%0d f_rdata=0x%02h", gf, gd, bus.f_rdata);
      check("sim_second_ack", {gf, gd}, 2'b10);
      check("sim_second_rdata", bus.f_rdata, 8'h99);
      check("sim_starts", start_cnt - s0, 2);
      check("sim_overlap", overlap_cnt, 0);

      // Sustained contention: grants alternate D,F,D,F,D,F with one idle cycle between.
      do_reset();
      bus.f_req = 1'b1; bus.f_addr = 8'h10;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
      for (int k = 0; k < 6; k++) begin
         wait_ack(50, gf, gd, to, idle, db);
         $display("txn rr%0d ack=%0d%0d idle=%0d", k, gf, gd, idle);
         check($sformatf("rr%0d_grant", k), {gf, gd}, (k % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("rr%0d_no_idle_before", k), idle, 0);
         check($sformatf("rr%0d_rdata", k), gd ? bus.d_rdata : bus.f_rdata, gd ? 8'h77 : 8'h99);
         if (gd) bus.d_req = 1'b0; else bus.f_req = 1'b0;
         tick();
         check($sformatf("rr%0d_gap_busy", k), bus.busy, 0);
         if (k < 5) begin
            if (gd) bus.d_req = 1'b1; else bus.f_req = 1'b1;
         end
      end
      bus.f_req = 1'b0; bus.d_req = 1'b0;
      check("rr_overlap", overlap_cnt, 0);

      // Reset two cycles after m_start, while WAITing.
      master_stuck = 1'b1;
      s0 = start_cnt; fa0 = f_ack_cnt; da0 = d_ack_cnt;
      bus.f_req = 1'b1; bus.f_addr = 8'h12;
      for (int i = 0; i < 20 && start_cnt == s0; i++) tick();
      check("midrst_started", start_cnt - s0, 1);
      tick();
      tick();
      rst = 1'b1;
      bus.f_req = 1'b0;
      tick();
      rst = 1'b0;
      $display("txn midrst busy=%0d f_rdata=0x%02h", bus.busy, bus.f_rdata);
      check_reset_state("midrst");
      tick();
      check("midrst_no_ack", (f_ack_cnt - fa0) + (d_ack_cnt - da0), 0);
      master_stuck = 1'b0;
      run_vec(vecs[0], 100);

      // Master never answers.
      master_stuck = 1'b1;
      fa0 = f_ack_cnt;
      bus.f_req = 1'b1; bus.f_addr = 8'h05;
`ifdef SPI_ARB_TIMEOUT_EN
      wait_ack(60, gf, gd, to, idle, db);
      c_ack = cyc;
      $display("txn timeout ack=%0d%0d err=%0d f_rdata=0x%02h", gf, gd, bus.f_err, bus.f_rdata);
      check("to_ack", {gf, gd}, 2'b10);
      check("to_err", bus.f_err, 1);
      check("to_rdata", bus.f_rdata, 8'h00);
      check("to_latency", c_ack - (start_cyc + 1), 16);
      bus.f_req = 1'b0;
      tick();
      check("to_err_pulse", bus.f_err, 0);
`else
      wait_ack(2000, gf, gd, to, idle, db);
      c_ack = cyc;
      $display("txn stuck ack=%0d%0d busy=%0d at cycle %0d", gf, gd, bus.busy, c_ack);
      check("stuck_waits", to, 1);
      check("stuck_no_ack", f_ack_cnt - fa0, 0);
      check("stuck_err", bus.f_err, 0);
      check("stuck_busy", bus.busy, 1);
      do_reset();
`endif
      master_stuck = 1'b0;
      run_vec(vecs[2], 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
